// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with sized loads/stores, a registered
// read and a valid/ready request/response handshake. Bad accesses return an error.
module data_memory_ctrl #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 256,
    parameter int ERRCNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ERRCNT_W-1:0] err_count
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int BW = $clog2(NB);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    logic                accept;
    logic                acc_err;
    logic                wr_fire;
    logic [3:0]          n_bytes;
    logic [AW-1:0]       addr_lo;
    logic [ADDR_W:0]     addr_end;
    logic                misaligned;
    logic                out_of_range;
    logic                bad_size;
    logic [7:0]          mem_rd [DEPTH_BYTES];
    logic [DATA_W-1:0]   rd_raw;
    logic [DATA_W-1:0]   rd_ext;
    logic [DATA_W-1:0]   keep_mask;
    logic                sign_bit;

    assign req_ready = (state_q == IDLE) || resp_ready;
    assign accept    = req_valid && req_ready;
    assign n_bytes   = 4'd1 << req_size;
    assign addr_lo   = req_addr[AW-1:0];

    // One extra bit so addr + n cannot wrap past the top of the address space;
    // this also flags any nonzero address bit above the memory size.
    assign addr_end     = {1'b0, req_addr} + (ADDR_W+1)'(n_bytes);
    assign out_of_range = addr_end > (ADDR_W+1)'(DEPTH_BYTES);
    assign misaligned   = (req_addr[2:0] & (3'(n_bytes) - 3'd1)) != 3'd0;
    assign bad_size     = (req_size == 2'd3) && (DATA_W == 32);
    assign acc_err      = misaligned || out_of_range || bad_size;

    // Memory writes are suppressed while reset is held so reset never alters contents.
    assign wr_fire = accept && req_we && !acc_err && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH_BYTES; gi++) begin : g_mem
            logic [7:0]    cell_q = 8'(gi);
            logic [7:0]    cell_d;
            logic [AW-1:0] off;

            // Offset of this byte within the access window; wraps high when below addr.
            assign off = AW'(gi) - addr_lo;

            always_comb begin
                cell_d = cell_q;
                if (wr_fire && ((AW+4)'(off) < (AW+4)'(n_bytes))) begin
                    cell_d = req_wdata[{off[BW-1:0], 3'b000} +: 8];
                end
            end

            always_ff @(posedge clk) begin
                cell_q <= cell_d;
            end

            assign mem_rd[gi] = cell_q;
        end

        for (gi = 0; gi < NB; gi++) begin : g_rd
            logic [AW-1:0] idx;
            assign idx = addr_lo + AW'(gi);
            assign rd_raw[8*gi +: 8] = mem_rd[idx];
        end
    endgenerate

    always_comb begin
        keep_mask = '1;
        sign_bit  = rd_raw[DATA_W-1];
        case (req_size)
            2'd0: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = rd_raw[7];
            end
            2'd1: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = rd_raw[15];
            end
            2'd2: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = rd_raw[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = rd_raw[DATA_W-1];
            end
        endcase
        rd_ext = (rd_raw & keep_mask) | (~keep_mask & {DATA_W{sign_bit && !req_unsigned}});
    end

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        err_count_d  = err_count_q;
        if (accept) begin
            state_d      = HOLD;
            resp_err_d   = acc_err;
            resp_rdata_d = (acc_err || req_we) ? '0 : rd_ext;
            if (acc_err && (err_count_q != '1)) begin
                err_count_d = err_count_q + ERRCNT_W'(1);
            end
        end else if ((state_q == HOLD) && resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign resp_valid = (state_q == HOLD);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed scenarios followed by random traffic,
// every response compared against a byte-array reference model.
module tb_data_memory_ctrl;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    byte unsigned ref_mem [DEPTH];
    int unsigned  ref_errs = 0;
    logic [63:0]  last_rd = '0;
    logic         last_err = 1'b0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DATA_W(64), .ADDR_W(64), .DEPTH_BYTES(DEPTH), .ERRCNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .err_count(err_count)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain byte-array semantics, value built arithmetically.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  output logic [63:0] exp_rd, output logic exp_err);
        longint unsigned n;
        longint unsigned val;
        n = 64'd1 << size;
        exp_rd = '0;
        exp_err = ((addr % n) != 0) || (addr > (DEPTH - n));
        if (exp_err) begin
            if (ref_errs < 65535) ref_errs++;
        end else if (we) begin
            for (int k = 0; k < int'(n); k++) ref_mem[addr + k] = wdata[8*k +: 8];
        end else begin
            val = 0;
            for (int k = 0; k < int'(n); k++) val = val | (longint'(ref_mem[addr + k]) << (8*k));
            if (!uns && n < 8 && ((val >> (8*n - 1)) & 1) == 1) val = val - (64'd1 << (8*n));
            exp_rd = val;
        end
    endfunction

    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input int stall, output logic [63:0] got);
        logic [63:0] exp_rd;
        logic        exp_err;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; resp_ready = 1'b1;
        #1;
        chk("req_ready_accept", {63'd0, req_ready}, 64'd1);
        model(we, size, uns, addr, wdata, exp_rd, exp_err);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (stall > 0) resp_ready = 1'b0;
        chk("resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
        chk("err_count", {48'd0, err_count}, 64'(ref_errs));
        $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d cnt=%0d",
                 we, size, uns, addr, wdata, resp_rdata, resp_err, err_count);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_err", {63'd0, resp_err}, {63'd0, exp_err});
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
        end
        last_rd = exp_rd;
        last_err = exp_err;
        got = resp_rdata;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid", {63'd0, resp_valid}, 64'd0);
        chk("drain_rdata_kept", resp_rdata, last_rd);
        chk("drain_err_kept", {63'd0, resp_err}, {63'd0, last_err});
    endtask

    initial begin
        logic [63:0] got;
        logic [1:0]  rsize;
        logic [63:0] raddr;
        int unsigned n;
        int unsigned r;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", {63'd0, resp_err}, 64'd0);
        chk("rst_errcnt", {48'd0, err_count}, 64'd0);

        txn(1'b0, 2'd3, 1'b0, 64'h10, '0, 0, got);
        chk("ld_d_10", got, 64'h1716151413121110);
        txn(1'b0, 2'd0, 1'b0, 64'h80, '0, 0, got);
        chk("ld_b_80_s", got, 64'hFFFFFFFFFFFFFF80);
        txn(1'b0, 2'd0, 1'b1, 64'h80, '0, 0, got);
        chk("ld_b_80_u", got, 64'h0000000000000080);
        txn(1'b0, 2'd1, 1'b0, 64'hFE, '0, 0, got);
        chk("ld_h_fe_s", got, 64'hFFFFFFFFFFFFFFFE);
        txn(1'b1, 2'd1, 1'b0, 64'h20, 64'h1234_5678_9ABC_BEEF, 0, got);
        chk("st_h_20_rdata", got, 64'd0);
        txn(1'b0, 2'd3, 1'b0, 64'h20, '0, 0, got);
        chk("ld_d_20", got, 64'h272625242322BEEF);
        idle_cycle();

        txn(1'b0, 2'd2, 1'b0, 64'h22, '0, 0, got);
        chk("err_w_22", {63'd0, resp_err}, 64'd1);
        chk("err_w_22_cnt", {48'd0, err_count}, 64'd1);
        txn(1'b0, 2'd3, 1'b0, 64'h100, '0, 0, got);
        chk("err_d_100_cnt", {48'd0, err_count}, 64'd2);
        txn(1'b0, 2'd3, 1'b0, 64'hF8, '0, 0, got);
        chk("ld_d_f8", got, 64'hFFFEFDFCFBFAF9F8);
        txn(1'b1, 2'd2, 1'b0, 64'h31, 64'hDEAD_BEEF_CAFE_F00D, 0, got);
        txn(1'b0, 2'd3, 1'b0, 64'h30, '0, 0, got);
        chk("ld_d_30_after_bad_st", got, 64'h3736353433323130);
        txn(1'b0, 2'd3, 1'b0, 64'h1_0000_0000_0010, '0, 0, got);
        chk("err_high_addr", {63'd0, resp_err}, 64'd1);

        txn(1'b0, 2'd3, 1'b0, 64'h08, '0, 3, got);
        chk("bp_ld_08", got, 64'h0F0E0D0C0B0A0908);
        txn(1'b0, 2'd3, 1'b0, 64'h40, '0, 0, got);
        chk("b2b_ld_40", got, 64'h4746454443424140);

        // Asynchronous reset while a response is held.
        txn(1'b0, 2'd3, 1'b0, 64'h08, '0, 1, got);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("async_rst_errcnt", {48'd0, err_count}, 64'd0);
        ref_errs = 0;
        last_rd = '0;
        last_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        txn(1'b0, 2'd3, 1'b0, 64'h20, '0, 0, got);
        chk("ld_d_20_after_rst", got, 64'h272625242322BEEF);

        for (int t = 0; t < 250; t++) begin
            rsize = 2'($urandom_range(0, 3));
            n = 32'd1 << rsize;
            r = $urandom_range(0, 9);
            if (r < 7) raddr = 64'($urandom_range(0, DEPTH / n - 1) * n);
            else if (r < 9) raddr = 64'($urandom_range(0, DEPTH + 7));
            else raddr = (64'd1 << $urandom_range(8, 63)) | 64'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)), raddr,
                {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, got);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
